// File: rtl/led_pulse_pio.sv
// rtl/led_pulse_pio.sv - Avalon-MM output PIO with set/clear and one-shot pulse engine
module led_pulse_pio #(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] pulse_mask;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] wd;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] len_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             done;
  logic             done_next;
  logic             done_set;
  logic             irq_en;
  logic             irq_en_next;
  logic             wr;
  logic             trig;
  logic             done_clear;
  logic [31:0]      read_next;
  logic             unused_writedata;

  assign wr               = chipselect & ~write_n;
  assign wd               = writedata[WIDTH-1:0];
  assign trig             = wr && (address == 3'd4) && (wd != '0);
  assign done_clear       = wr && (address == 3'd5) && writedata[0];
  assign unused_writedata = ^writedata;

  // Pins show the software-owned data bits with any active pulse bits on top.
  assign out_port = data_reg | pulse_mask;
  assign irq      = done & irq_en;

  // Software-visible register writes: data, pulse length (0 coerced to 1), irq enable.
  always_comb begin
    data_next   = data_reg;
    len_next    = pulse_len;
    irq_en_next = irq_en;
    if (wr) begin
      case (address)
        3'd0: data_next = wd;
        3'd1: len_next = (writedata[CNT_W-1:0] == '0) ? CNT_W'(1) : writedata[CNT_W-1:0];
        3'd2: data_next = data_reg | wd;
        3'd3: data_next = data_reg & ~wd;
        3'd6: irq_en_next = writedata[0];
        default: ;
      endcase
    end
  end

  // Pulse engine next state; a retrigger always beats expiry, and a done set beats a clear.
  always_comb begin
    state_next = state;
    mask_next  = pulse_mask;
    count_next = count;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          mask_next  = wd;
          count_next = pulse_len;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (trig) begin
          mask_next  = pulse_mask | wd;
          count_next = pulse_len;
        end else if (count == CNT_W'(1)) begin
          mask_next  = '0;
          count_next = '0;
          done_set   = 1'b1;
          state_next = IDLE;
        end else begin
          count_next = count - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    done_next = done_set | (done & ~done_clear);
  end

  // Read mux sampled every cycle regardless of chipselect; unused bits are zero.
  always_comb begin
    read_next = '0;
    case (address)
      3'd0, 3'd2, 3'd3: read_next = 32'(data_reg);
      3'd1:             read_next = 32'(pulse_len);
      3'd4:             read_next = 32'(pulse_mask);
      3'd5:             read_next = {30'd0, (pulse_mask != '0), done};
      3'd6:             read_next = {31'd0, irq_en};
      default:          read_next = '0;
    endcase
  end

  // All state, with asynchronous reset so the pins drop back without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      data_reg   <= RESET_VALUE;
      pulse_len  <= CNT_W'(1);
      pulse_mask <= '0;
      count      <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      readdata   <= '0;
    end else begin
      state      <= state_next;
      data_reg   <= data_next;
      pulse_len  <= len_next;
      pulse_mask <= mask_next;
      count      <= count_next;
      done       <= done_next;
      irq_en     <= irq_en_next;
      readdata   <= read_next;
    end
  end

endmodule

// File: tb/tb_led_pulse_pio.sv
// tb/tb_led_pulse_pio.sv - scoreboard bench for led_pulse_pio against a cycle-count reference model
module tb_led_pulse_pio;

  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  out_port;

  led_pulse_pio #(.WIDTH(8), .CNT_W(24), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: pulse expiry is tracked as an absolute clock-edge number.
  logic [7:0]  m_data;
  logic [23:0] m_len;
  logic [7:0]  m_mask;
  longint      m_end;
  bit          m_done;
  bit          m_irq_en;
  longint      cyc = 0;
  logic [31:0] rq[$];
  bit          mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = RV; m_len = 24'd1; m_mask = 8'h00; m_end = 0; m_done = 0; m_irq_en = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd2, 3'd3: return {24'd0, m_data};
      3'd1:             return {8'd0, m_len};
      3'd4:             return {24'd0, m_mask};
      3'd5:             return {30'd0, (m_mask != 8'h00), m_done};
      3'd6:             return {31'd0, m_irq_en};
      default:          return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive at negedge, then advance the model at the active edge.
  task automatic cycle(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wdat);
    bit wr;
    bit trig;
    logic [7:0] wd;
    @(negedge clk);
    chipselect = cs; write_n = wn; address = a; writedata = wdat;
    @(posedge clk);
    rq.push_back(model_read(a));
    cyc++;
    wr = cs && !wn;
    trig = 0;
    wd = wdat[7:0];
    if (wr) begin
      case (a)
        3'd0: m_data = wd;
        3'd1: m_len = (wdat[23:0] == 24'd0) ? 24'd1 : wdat[23:0];
        3'd2: m_data = m_data | wd;
        3'd3: m_data = m_data & ~wd;
        3'd4: if (wd != 8'h00) begin
                m_mask = m_mask | wd;
                m_end = cyc + longint'(m_len);
                trig = 1;
              end
        3'd5: if (wdat[0]) m_done = 0;
        3'd6: m_irq_en = wdat[0];
        default: ;
      endcase
    end
    if (!trig && m_mask != 8'h00 && cyc == m_end) begin
      m_mask = 8'h00;
      m_done = 1;
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    cycle(1, 0, a, d);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cycle(1, 1, a, 32'd0);
  endtask

  task automatic now_check(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    check(name, act_sel, exp);
  endtask

  // Monitor: pins and irq every cycle, plus the queued read response of the previous cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_port", {24'd0, out_port}, {24'd0, m_data | m_mask});
        check("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
        if (rq.size() > 0) check("readdata", readdata, rq.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    mon_en = 1;
    repeat (2) @(negedge clk);
    check("reset_out_port", {24'd0, out_port}, 32'h0000_00A5);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;

    rd_reg(3'd1);
    rd_reg(3'd0);

    wr_reg(3'd0, 32'h0000_000F); #1 check("data_0f", {24'd0, out_port}, 32'h0F);
    wr_reg(3'd2, 32'h0000_0030); #1 check("outset_3f", {24'd0, out_port}, 32'h3F);
    wr_reg(3'd3, 32'h0000_0005); #1 check("outclr_3a", {24'd0, out_port}, 32'h3A);
    rd_reg(3'd0);
    rd_reg(3'd7);

    wr_reg(3'd1, 32'd5);
    wr_reg(3'd6, 32'd1);
    wr_reg(3'd0, 32'd0);
    wr_reg(3'd4, 32'h0000_0081); #1 check("pulse_start", {24'd0, out_port}, 32'h81);
    for (int k = 1; k <= 6; k++) begin
      rd_reg(3'd5);
      #1 check("pulse_len5", {24'd0, out_port}, (k < 5) ? 32'h81 : 32'h00);
    end
    check("done_irq", {31'd0, irq}, 32'd1);
    wr_reg(3'd5, 32'd1); #1 check("w1c_irq", {31'd0, irq}, 32'd0);
    rd_reg(3'd5);

    wr_reg(3'd1, 32'd4);
    wr_reg(3'd4, 32'h0000_0001);
    rd_reg(3'd5);
    rd_reg(3'd4);
    wr_reg(3'd4, 32'h0000_0002); #1 check("retrig", {24'd0, out_port}, 32'h03);
    for (int k = 1; k <= 5; k++) begin
      rd_reg(3'd5);
      #1 check("retrig_out", {24'd0, out_port}, (k < 4) ? 32'h03 : 32'h00);
      check("retrig_irq", {31'd0, irq}, (k < 4) ? 32'd0 : 32'd1);
    end
    wr_reg(3'd5, 32'd1);

    wr_reg(3'd1, 32'd0);
    rd_reg(3'd1);
    wr_reg(3'd1, 32'h0100_0000);
    rd_reg(3'd1);
    wr_reg(3'd4, 32'h0000_0010); #1 check("len1_on", {24'd0, out_port}, 32'h10);
    wr_reg(3'd5, 32'd1); #1 check("len1_off", {24'd0, out_port}, 32'h00);
    check("set_beats_clear", {31'd0, irq}, 32'd1);
    rd_reg(3'd5);
    wr_reg(3'd4, 32'd0);
    rd_reg(3'd4);

    wr_reg(3'd1, 32'd100);
    wr_reg(3'd4, 32'h0000_00FF);
    repeat (10) rd_reg(3'd4);
    #3;
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b0;
    #1;
    model_reset();
    rq.delete();
    check("async_reset_out", {24'd0, out_port}, 32'h0000_00A5);
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd_reg(3'd5);
    repeat (120) rd_reg(3'd4);
    #1 check("no_stale_pulse", {24'd0, out_port}, 32'h0000_00A5);

    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) begin
        d = 32'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) d[31:24] = 8'($urandom);
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) >= 4, a, d);
    end
    repeat (20) rd_reg(3'd5);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
